// File: rtl/vdp_pattern_gen.sv
// -----------------------------------------------------------------------------
// vdp_pattern_gen
// Pattern generation controller for the VDP display pipeline. It tracks the
// name-table pattern counter, captures name/colour/generator bytes delivered
// by the VRAM access sequencer, buffers generator entries in a 2-entry
// prefetch queue and serialises them into a 4-bit colour index.
//
// Ports:
//   clk_i, reset_i       clock, asynchronous active-high reset
//   clk_en_pix_i         pixel clock enable (advances the shifter)
//   clk_en_acc_i         VRAM access-slot enable
//   opmode_i             0 TEXT1, 1 GRAPH1, 2 GRAPH2, 3 MULTIC, 4 TEXT2
//   access_type_i        0 none, 1 PNT, 2 PCT, 3 PGT
//   num_line_i           signed line number, negative = border/blank
//   line_start_i         start-of-line pulse: clears pixel counter, flushes queue
//   vram_d_i             VRAM read data
//   vert_inc_i           end-of-line vertical increment strobe
//   vsync_n_i            active-low vertical sync (clears counter and flags)
//   reg_col1_i/col0_i    text foreground / background colour
//   pat_table_o          pattern counter (name-table index)
//   pat_name_o           last fetched pattern name
//   pat_col_o            current pixel colour index
//   underrun_o           sticky: boundary found the queue empty
//   overflow_o           sticky: push onto a full queue was dropped
//
// Queue handshake: a PGT slot is a push, a cell boundary is a pop. Within one
// edge the pop is applied first, so a full queue accepts a same-edge push. A
// pushed entry is never consumed on the edge it arrives.
// -----------------------------------------------------------------------------
module vdp_pattern_gen #(
    parameter int PAT_W      = 8,
    parameter int TABLE_W    = 11,
    parameter int TEXT1_COLS = 40,
    parameter int TEXT2_COLS = 80,
    parameter int GRAPH_COLS = 32
) (
    input  logic               clk_i,
    input  logic               reset_i,
    input  logic               clk_en_pix_i,
    input  logic               clk_en_acc_i,
    input  logic [2:0]         opmode_i,
    input  logic [1:0]         access_type_i,
    input  logic [8:0]         num_line_i,
    input  logic               line_start_i,
    input  logic [7:0]         vram_d_i,
    input  logic               vert_inc_i,
    input  logic               vsync_n_i,
    input  logic [3:0]         reg_col1_i,
    input  logic [3:0]         reg_col0_i,
    output logic [TABLE_W-1:0] pat_table_o,
    output logic [7:0]         pat_name_o,
    output logic [3:0]         pat_col_o,
    output logic               underrun_o,
    output logic               overflow_o
);

    localparam logic [2:0] MODE_TEXT1  = 3'd0;
    localparam logic [2:0] MODE_GRAPH1 = 3'd1;
    localparam logic [2:0] MODE_GRAPH2 = 3'd2;
    localparam logic [2:0] MODE_MULTIC = 3'd3;
    localparam logic [2:0] MODE_TEXT2  = 3'd4;

    localparam logic [1:0] ACC_PNT = 2'd1;
    localparam logic [1:0] ACC_PCT = 2'd2;
    localparam logic [1:0] ACC_PGT = 2'd3;

    // Multicolour cells show the high nibble colour for the left half.
    localparam logic [PAT_W-1:0] MULTIC_PAT = {{(PAT_W/2){1'b1}}, {(PAT_W-PAT_W/2){1'b0}}};

    // Registers
    logic [TABLE_W-1:0] r_pat_table;
    logic [7:0]         r_pat_name;
    logic [7:0]         r_col_temp;
    logic [PAT_W-1:0]   r_q_pat [2];
    logic [7:0]         r_q_col [2];
    logic [1:0]         r_q_cnt;
    logic [PAT_W-1:0]   r_shifter;
    logic [7:0]         r_cur_col;
    logic [2:0]         r_pix_cnt;
    logic [3:0]         r_pat_col;
    logic               r_underrun;
    logic               r_overflow;

    // Decode
    logic               w_text_mode;
    logic [2:0]         w_last_pix;
    logic               w_pnt;
    logic               w_pct;
    logic               w_pgt;
    logic               w_pop;
    logic               w_push;
    logic [PAT_W-1:0]   w_push_pat;
    logic [7:0]         w_push_col;

    assign w_text_mode = (opmode_i == MODE_TEXT1) || (opmode_i == MODE_TEXT2);
    assign w_last_pix  = w_text_mode ? 3'd5 : 3'd7;
    assign w_pnt       = clk_en_acc_i && (access_type_i == ACC_PNT);
    assign w_pct       = clk_en_acc_i && (access_type_i == ACC_PCT);
    assign w_pgt       = clk_en_acc_i && (access_type_i == ACC_PGT);

    // line_start_i wins over both queue operations on its cycle.
    assign w_pop  = !line_start_i && clk_en_pix_i && (r_pix_cnt == w_last_pix) && (r_q_cnt != 2'd0);
    assign w_push = !line_start_i && w_pgt;

    assign w_push_pat = (opmode_i == MODE_MULTIC) ? MULTIC_PAT : vram_d_i;
    assign w_push_col = (opmode_i == MODE_MULTIC) ? vram_d_i : r_col_temp;

    // Prefetch queue next state: head is entry 0, pop first then push.
    logic [PAT_W-1:0]   w_q_pat_n [2];
    logic [7:0]         w_q_col_n [2];
    logic [1:0]         w_q_cnt_n;
    logic               w_ovf_evt;

    always_comb begin
        w_q_pat_n[0] = r_q_pat[0];
        w_q_pat_n[1] = r_q_pat[1];
        w_q_col_n[0] = r_q_col[0];
        w_q_col_n[1] = r_q_col[1];
        w_q_cnt_n    = r_q_cnt;
        w_ovf_evt    = 1'b0;
        if (line_start_i) begin
            w_q_cnt_n = 2'd0;
        end else begin
            if (w_pop) begin
                w_q_pat_n[0] = r_q_pat[1];
                w_q_col_n[0] = r_q_col[1];
                w_q_cnt_n    = r_q_cnt - 2'd1;
            end
            if (w_push) begin
                if (w_q_cnt_n == 2'd2) begin
                    w_ovf_evt = 1'b1;
                end else begin
                    w_q_pat_n[w_q_cnt_n[0]] = w_push_pat;
                    w_q_col_n[w_q_cnt_n[0]] = w_push_col;
                    w_q_cnt_n               = w_q_cnt_n + 2'd1;
                end
            end
        end
    end

    // Pixel shifter next state. At a boundary the old queue head is used, so
    // an entry pushed on the same edge cannot rescue an empty queue.
    logic [PAT_W-1:0]   w_shift_n;
    logic [7:0]         w_cur_col_n;
    logic [2:0]         w_pix_n;
    logic               w_udr_evt;

    always_comb begin
        w_shift_n   = r_shifter;
        w_cur_col_n = r_cur_col;
        w_pix_n     = r_pix_cnt;
        w_udr_evt   = 1'b0;
        if (line_start_i) begin
            w_pix_n = 3'd0;
        end else if (clk_en_pix_i) begin
            if (r_pix_cnt == w_last_pix) begin
                w_pix_n = 3'd0;
                if (r_q_cnt != 2'd0) begin
                    w_shift_n   = r_q_pat[0];
                    w_cur_col_n = r_q_col[0];
                end else begin
                    w_shift_n = '0;
                    w_udr_evt = 1'b1;
                end
            end else begin
                w_shift_n = {r_shifter[PAT_W-2:0], 1'b0};
                w_pix_n   = r_pix_cnt + 3'd1;
            end
        end
    end

    // Colour of the pixel that becomes current on this pixel edge.
    logic [3:0] w_pix_col;

    always_comb begin
        w_pix_col = 4'd0;
        case (opmode_i)
            MODE_TEXT1, MODE_TEXT2:
                w_pix_col = w_shift_n[PAT_W-1] ? reg_col1_i : reg_col0_i;
            MODE_GRAPH1, MODE_GRAPH2, MODE_MULTIC:
                w_pix_col = w_shift_n[PAT_W-1] ? w_cur_col_n[7:4] : w_cur_col_n[3:0];
            default:
                w_pix_col = 4'd0;
        endcase
    end

    // Pattern counter: one combined step for increment and rewind.
    logic [TABLE_W-1:0] w_cols;
    logic               w_rewind;
    logic [TABLE_W-1:0] w_table_n;

    always_comb begin
        w_cols = '0;
        case (opmode_i)
            MODE_TEXT1:                            w_cols = TABLE_W'(TEXT1_COLS);
            MODE_TEXT2:                            w_cols = TABLE_W'(TEXT2_COLS);
            MODE_GRAPH1, MODE_GRAPH2, MODE_MULTIC: w_cols = TABLE_W'(GRAPH_COLS);
            default:                               w_cols = '0;
        endcase
    end

    // Every eighth line (line[2:0] == 7) keeps the advanced counter so the
    // next character row starts where this one ended.
    assign w_rewind  = vert_inc_i && !num_line_i[8] && (num_line_i[2:0] != 3'b111);
    assign w_table_n = !vsync_n_i ? '0
                     : r_pat_table + {{(TABLE_W-1){1'b0}}, w_pnt}
                       - (w_rewind ? w_cols : '0);

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            r_pat_table <= '0;
            r_pat_name  <= '0;
            r_col_temp  <= '0;
            r_q_pat[0]  <= '0;
            r_q_pat[1]  <= '0;
            r_q_col[0]  <= '0;
            r_q_col[1]  <= '0;
            r_q_cnt     <= '0;
            r_shifter   <= '0;
            r_cur_col   <= '0;
            r_pix_cnt   <= '0;
            r_pat_col   <= '0;
            r_underrun  <= 1'b0;
            r_overflow  <= 1'b0;
        end else begin
            r_pat_table <= w_table_n;
            if (w_pnt) r_pat_name <= vram_d_i;
            if (w_pct) r_col_temp <= vram_d_i;
            r_q_pat[0]  <= w_q_pat_n[0];
            r_q_pat[1]  <= w_q_pat_n[1];
            r_q_col[0]  <= w_q_col_n[0];
            r_q_col[1]  <= w_q_col_n[1];
            r_q_cnt     <= w_q_cnt_n;
            r_shifter   <= w_shift_n;
            r_cur_col   <= w_cur_col_n;
            r_pix_cnt   <= w_pix_n;
            if (clk_en_pix_i) r_pat_col <= w_pix_col;
            // Clearing during vsync takes priority over a new event.
            if (!vsync_n_i) begin
                r_underrun <= 1'b0;
                r_overflow <= 1'b0;
            end else begin
                if (w_udr_evt) r_underrun <= 1'b1;
                if (w_ovf_evt) r_overflow <= 1'b1;
            end
        end
    end

    assign pat_table_o = r_pat_table;
    assign pat_name_o  = r_pat_name;
    assign pat_col_o   = r_pat_col;
    assign underrun_o  = r_underrun;
    assign overflow_o  = r_overflow;

endmodule

// File: tb/tb_vdp_pattern_gen.sv
// -----------------------------------------------------------------------------
// tb_vdp_pattern_gen
// Directed scenarios followed by randomized stimulus. A behavioural model
// (prefetch queue as a SV queue, current cell as pattern byte plus pixel
// index) predicts every output after each clock edge.
// -----------------------------------------------------------------------------
module tb_vdp_pattern_gen;

    // Clock / reset
    logic        clk_i = 1'b0;
    logic        reset_i;
    always #5 clk_i = ~clk_i;

    logic        clk_en_pix_i;
    logic        clk_en_acc_i;
    logic [2:0]  opmode_i;
    logic [1:0]  access_type_i;
    logic [8:0]  num_line_i;
    logic        line_start_i;
    logic [7:0]  vram_d_i;
    logic        vert_inc_i;
    logic        vsync_n_i;
    logic [3:0]  reg_col1_i;
    logic [3:0]  reg_col0_i;
    logic [10:0] pat_table_o;
    logic [7:0]  pat_name_o;
    logic [3:0]  pat_col_o;
    logic        underrun_o;
    logic        overflow_o;

    vdp_pattern_gen dut (
        .clk_i         (clk_i),
        .reset_i       (reset_i),
        .clk_en_pix_i  (clk_en_pix_i),
        .clk_en_acc_i  (clk_en_acc_i),
        .opmode_i      (opmode_i),
        .access_type_i (access_type_i),
        .num_line_i    (num_line_i),
        .line_start_i  (line_start_i),
        .vram_d_i      (vram_d_i),
        .vert_inc_i    (vert_inc_i),
        .vsync_n_i     (vsync_n_i),
        .reg_col1_i    (reg_col1_i),
        .reg_col0_i    (reg_col0_i),
        .pat_table_o   (pat_table_o),
        .pat_name_o    (pat_name_o),
        .pat_col_o     (pat_col_o),
        .underrun_o    (underrun_o),
        .overflow_o    (overflow_o)
    );

    int n_checks = 0;
    int n_errors = 0;

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Reference model / scoreboard state
    logic [15:0] exp_q[$];      // {pattern, colour} entries awaiting a boundary
    int          m_table;
    logic [7:0]  m_name;
    logic [7:0]  m_temp;
    int          m_pix;
    logic [7:0]  m_pat;         // pattern byte of the current cell
    int          m_k;           // pixels already shown from m_pat
    logic [7:0]  m_cur_col;
    logic [3:0]  m_col;
    bit          m_udr;
    bit          m_ovf;

    task automatic model_reset();
        exp_q.delete();
        m_table = 0; m_name = 0; m_temp = 0; m_pix = 0;
        m_pat = 0; m_k = 0; m_cur_col = 0; m_col = 0;
        m_udr = 0; m_ovf = 0;
    endtask

    task automatic model_step();
        int          len;
        int          cols;
        bit          pnt, pct, pgt, rew, msb;
        logic [15:0] ent;
        len = (opmode_i == 3'd0 || opmode_i == 3'd4) ? 6 : 8;
        pnt = clk_en_acc_i && access_type_i == 2'd1;
        pct = clk_en_acc_i && access_type_i == 2'd2;
        pgt = clk_en_acc_i && access_type_i == 2'd3;
        ent = (opmode_i == 3'd3) ? {8'hF0, vram_d_i} : {vram_d_i, m_temp};
        if (line_start_i) begin
            exp_q.delete();
            m_pix = 0;
        end else if (clk_en_pix_i) begin
            if (m_pix == len - 1) begin
                m_pix = 0;
                m_k   = 0;
                if (exp_q.size() > 0) begin
                    {m_pat, m_cur_col} = exp_q.pop_front();
                end else begin
                    m_pat = 8'h00;
                    m_udr = 1;
                end
            end else begin
                m_pix = (m_pix + 1) % 8;
                if (m_k < 8) m_k++;
            end
        end
        if (pgt && !line_start_i) begin
            if (exp_q.size() == 2) m_ovf = 1;
            else exp_q.push_back(ent);
        end
        if (clk_en_pix_i) begin
            msb = (m_k < 8) ? m_pat[7 - m_k] : 1'b0;
            case (opmode_i)
                3'd0, 3'd4:       m_col = msb ? reg_col1_i : reg_col0_i;
                3'd1, 3'd2, 3'd3: m_col = msb ? m_cur_col[7:4] : m_cur_col[3:0];
                default:          m_col = 4'd0;
            endcase
        end
        case (opmode_i)
            3'd0:             cols = 40;
            3'd4:             cols = 80;
            3'd1, 3'd2, 3'd3: cols = 32;
            default:          cols = 0;
        endcase
        rew = vert_inc_i && !num_line_i[8] && num_line_i[2:0] != 3'd7;
        if (pnt) m_name = vram_d_i;
        if (pct) m_temp = vram_d_i;
        if (!vsync_n_i) begin
            m_table = 0;
            m_udr   = 0;
            m_ovf   = 0;
        end else begin
            m_table = (m_table + (pnt ? 1 : 0) - (rew ? cols : 0)) & 32'h7FF;
        end
    endtask

    // One clock: advance the model on the edge, compare 1 ns later.
    task automatic tick();
        @(posedge clk_i);
        model_step();
        #1;
        check_val("table", 32'(pat_table_o), 32'(m_table));
        check_val("name",  32'(pat_name_o),  32'(m_name));
        check_val("col",   32'(pat_col_o),   32'(m_col));
        check_val("udr",   32'(underrun_o),  32'(m_udr));
        check_val("ovf",   32'(overflow_o),  32'(m_ovf));
    endtask

    // Driver tasks
    task automatic acc(input logic [1:0] typ, input logic [7:0] d);
        clk_en_acc_i  = 1'b1;
        access_type_i = typ;
        vram_d_i      = d;
        tick();
        clk_en_acc_i  = 1'b0;
        access_type_i = 2'd0;
    endtask

    task automatic pix(input int n);
        clk_en_pix_i = 1'b1;
        repeat (n) tick();
        clk_en_pix_i = 1'b0;
    endtask

    task automatic new_line();
        line_start_i = 1'b1;
        tick();
        line_start_i = 1'b0;
    endtask

    task automatic check_all_zero(input string tag);
        check_val({tag, "_table"}, 32'(pat_table_o), 32'd0);
        check_val({tag, "_name"},  32'(pat_name_o),  32'd0);
        check_val({tag, "_col"},   32'(pat_col_o),   32'd0);
        check_val({tag, "_udr"},   32'(underrun_o),  32'd0);
        check_val({tag, "_ovf"},   32'(overflow_o),  32'd0);
    endtask

    logic [3:0] g1_exp [8];

    initial begin
        reset_i = 1'b1;
        clk_en_pix_i = 0; clk_en_acc_i = 0; opmode_i = 0; access_type_i = 0;
        num_line_i = 0; line_start_i = 0; vram_d_i = 0; vert_inc_i = 0;
        vsync_n_i = 1; reg_col1_i = 0; reg_col0_i = 0;
        model_reset();
        #12;
        check_all_zero("rst");
        @(negedge clk_i);
        reset_i = 1'b0;

        // TEXT1: 40 name fetches
        opmode_i = 3'd0;
        repeat (40) acc(2'd1, 8'($urandom));
        check_val("text1_pnt40", 32'(pat_table_o), 32'd40);

        // TEXT2 rewind rules
        opmode_i = 3'd4;
        repeat (40) acc(2'd1, 8'($urandom));
        check_val("text2_cnt80", 32'(pat_table_o), 32'd80);
        num_line_i = 9'd3; vert_inc_i = 1'b1; tick(); vert_inc_i = 1'b0;
        check_val("rewind_l3", 32'(pat_table_o), 32'd0);
        repeat (80) acc(2'd1, 8'($urandom));
        num_line_i = 9'd7; vert_inc_i = 1'b1; tick(); vert_inc_i = 1'b0;
        check_val("no_rewind_l7", 32'(pat_table_o), 32'd80);
        num_line_i = 9'h1FF; vert_inc_i = 1'b1; tick(); vert_inc_i = 1'b0;
        check_val("no_rewind_neg", 32'(pat_table_o), 32'd80);

        // GRAPH1 colour split
        g1_exp = '{4'h4, 4'hA, 4'h4, 4'hA, 4'hA, 4'hA, 4'hA, 4'hA};
        opmode_i = 3'd1;
        new_line();
        acc(2'd2, 8'h4A);
        acc(2'd3, 8'hA0);
        pix(7);
        clk_en_pix_i = 1'b1;
        for (int i = 0; i < 8; i++) begin
            tick();
            check_val($sformatf("g1_px%0d", i), 32'(pat_col_o), 32'(g1_exp[i]));
        end
        clk_en_pix_i = 1'b0;

        // MULTIC: colour byte halves
        opmode_i = 3'd3;
        new_line();
        acc(2'd3, 8'h3C);
        pix(7);
        clk_en_pix_i = 1'b1;
        for (int i = 0; i < 8; i++) begin
            tick();
            check_val($sformatf("mc_px%0d", i), 32'(pat_col_o), (i < 4) ? 32'h3 : 32'hC);
        end
        clk_en_pix_i = 1'b0;
        check_val("udr_before", 32'(underrun_o), 32'd0);

        // Overflow, underrun, vsync clear
        new_line();
        repeat (3) acc(2'd3, 8'($urandom));
        check_val("overflow_set", 32'(overflow_o), 32'd1);
        opmode_i = 3'd0; reg_col0_i = 4'h5; reg_col1_i = 4'h9;
        new_line();
        pix(6);
        check_val("underrun_set", 32'(underrun_o), 32'd1);
        check_val("underrun_bg", 32'(pat_col_o), 32'h5);
        vsync_n_i = 1'b0; tick(); vsync_n_i = 1'b1;
        check_val("vsync_udr", 32'(underrun_o), 32'd0);
        check_val("vsync_ovf", 32'(overflow_o), 32'd0);
        check_val("vsync_table", 32'(pat_table_o), 32'd0);

        // GRAPH2: PNT and rewind together
        opmode_i = 3'd2;
        repeat (64) acc(2'd1, 8'($urandom));
        check_val("g2_cnt64", 32'(pat_table_o), 32'd64);
        num_line_i = 9'd0; vert_inc_i = 1'b1;
        acc(2'd1, 8'h77);
        vert_inc_i = 1'b0;
        check_val("g2_combined", 32'(pat_table_o), 32'd33);

        // Asynchronous reset mid-cell
        new_line();
        acc(2'd2, 8'h5B);
        acc(2'd3, 8'hC3);
        pix(10);
        #2;
        reset_i = 1'b1;
        #1;
        check_all_zero("async_rst");
        model_reset();
        @(negedge clk_i);
        reset_i = 1'b0;

        // Randomized traffic
        for (int n = 0; n < 2500; n++) begin
            opmode_i      = (n % 200 < 180) ? 3'($urandom_range(0, 4)) : 3'($urandom_range(5, 7));
            clk_en_pix_i  = 1'($urandom_range(0, 1));
            clk_en_acc_i  = 1'($urandom_range(0, 1));
            access_type_i = 2'($urandom_range(0, 3));
            vram_d_i      = 8'($urandom);
            num_line_i    = 9'($urandom);
            line_start_i  = ($urandom_range(0, 19) == 0);
            vert_inc_i    = ($urandom_range(0, 29) == 0);
            vsync_n_i     = ($urandom_range(0, 59) != 0);
            reg_col1_i    = 4'($urandom);
            reg_col0_i    = 4'($urandom);
            tick();
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule

// File: doc/vdp_pattern_gen.md
# vdp_pattern_gen

Parametrised pattern generation controller for the VDP display pipeline. It sits between the VRAM access sequencer and the colour mux. It tracks the name-table pattern counter, captures name, colour and generator bytes, and serialises pattern pixels into a 4-bit colour index. Compared with the previous generation it adds:
- an 80-column text mode (TEXT2) with 6-pixel cells;
- a 2-entry prefetch queue that decouples VRAM fetch timing from the pixel shifter;
- sticky underrun/overflow diagnostics.

## Interface
Parameters:
- PAT_W, 8: bits per generator byte / shifter width.
- TABLE_W, 11: pattern counter width (covers 80×24 = 1920).
- TEXT1_COLS, 40: columns per row, TEXT1.
- TEXT2_COLS, 80: columns per row, TEXT2.
- GRAPH_COLS, 32: columns per row, GRAPH1/GRAPH2/MULTIC.

Ports:
- clk_i  in  1  clock.
- reset_i  in  1  reset, asynchronous, active-high.
- clk_en_pix_i  in  1  pixel clock enable.
- clk_en_acc_i  in  1  VRAM access-slot enable.
- opmode_i  in  3  mode select: 0 TEXT1, 1 GRAPH1, 2 GRAPH2, 3 MULTIC, 4 TEXT2; 5–7 are undefined.
- access_type_i  in  2  access type: 0 none, 1 PNT, 2 PCT, 3 PGT.
- num_line_i  in  9  signed current line; negative means border/blank.
- line_start_i  in  1  one-cycle pulse at the start of each line.
- vram_d_i  in  8  VRAM read data.
- vert_inc_i  in  1  end-of-line vertical increment strobe.
- vsync_n_i  in  1  active-low vertical sync.
- reg_col1_i, reg_col0_i  in  4 each  text foreground / background colour.
- pat_table_o  out  TABLE_W  pattern counter (name-table index).
- pat_name_o  out  8  last fetched pattern name.
- pat_col_o  out  4  current pixel colour (combinational from registers).
- underrun_o, overflow_o  out  1 each  sticky diagnostic flags.

## Operation
- Reset: every register and output is 0. The queue is empty and the pixel counter is 0.

Access slots (when clk_en_acc_i is high):
- PNT: load pat_name_o ← vram_d_i and request a counter increment.
- PCT: load colour temp ← vram_d_i.
- PGT, all modes except MULTIC: push {pattern = vram_d_i, colour = temp}.
- PGT, MULTIC: push {pattern = 0xF0, colour = vram_d_i}.
- Push onto a full queue: drop the entry and set overflow_o.

Pixel shifter (when clk_en_pix_i is high):
- Cell length L = 6 in TEXT1/TEXT2, 8 otherwise. The pixel counter runs 0..L-1.
- Counter ≠ L-1: shift the shifter left by one.
- Counter = L-1 (boundary): pop the queue head into shifter and current colour.
- Boundary with an empty queue: load shifter = 0 and set underrun_o.
- Pop and push on the same cycle: pop first, then the push is accepted, so a full queue does not overflow.
- line_start_i: clear the pixel counter and flush the queue. It has priority over a push and a pop on that cycle.

Colour output:
- TEXT modes: pat_col_o = shifter MSB ? reg_col1_i : reg_col0_i.
- GRAPH1, GRAPH2, MULTIC: pat_col_o = MSB ? colour[7:4] : colour[3:0].
- Undefined modes: 0.

Pattern counter:
- Set C = column count for the active mode. Undefined modes use C = 0.
- Rewind condition: vert_inc_i high, num_line_i ≥ 0, and num_line_i[2:0] ≠ 7.
- Next value:
  - vsync_n_i = 0: 0, with highest priority.
  - otherwise: counter + (PNT increment ? 1 : 0) − (rewind ? C : 0).
- Arithmetic is modulo 2^TABLE_W.
- Sticky flags clear only on reset or while vsync_n_i = 0.

## Timing
- An access slot updates its registers and queue on the same clk_i edge.
- A pushed entry is visible at the next boundary edge at the earliest: a push and a boundary on the same edge with an empty queue still underruns.
- pat_col_o changes only on edges where clk_en_pix_i is high.
- A counter update (increment, rewind or clear) appears on pat_table_o one edge after the strobe.
- A simultaneous PNT and rewind take a single combined step.
- Asserting reset_i mid-line returns everything to 0 asynchronously. Operation resumes from an empty queue.

## Test plan
- Reset → pat_table_o = 0, pat_col_o = 0, both flags 0. Then 40 PNT slots in TEXT1 → pat_table_o = 40.
- TEXT2, counter = 80, num_line_i = 3, vert_inc_i → counter = 0. Same with num_line_i = 7 → stays 80. Same with num_line_i = −1 → stays 80.
- GRAPH1: PCT 0x4A then PGT 0xA0, then run 8 pixels after the boundary → pat_col_o = 4, A, 4, A, A, A, A, A.
- MULTIC: PGT 0x3C → 4 pixels of 3, then 4 pixels of C.
- Three PGT pushes with no boundary in between → overflow_o = 1. A boundary with an empty queue → underrun_o = 1 and pixels use reg_col0_i in TEXT1. vsync_n_i low → both flags cleared and counter = 0.
- PNT and rewind on the same edge in GRAPH2, counter 64 → 33. Assert reset_i mid-cell → all outputs 0 immediately.
